// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - multi-cycle load/store unit; optional WAIT timeout via LSU_TIMEOUT_EN
module lsu_pipe #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   base_addr,
    input  logic [31:0]       imm,
    input  logic [XLEN-1:0]   store_data,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              done,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              fault_valid,
    output logic [1:0]        fault_cause,
    output logic [XLEN-1:0]   fault_addr,
    output logic              busy
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_FAULT} state_t;
    state_t state;

    logic [XLEN-1:0] eff_addr;
    logic [LW-1:0]   lane;
    logic            code_ok;
    logic            illegal;
    logic            misaligned;
    logic [NB-1:0]   strb_base;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      func3_q;
    logic [4:0]      rd_q;
    logic            load_q;
    logic [XLEN-1:0] rsp_shifted;
    logic [XLEN-1:0] load_ext;
    logic            timeout_hit;

    generate
        if (!(XLEN == 32 || XLEN == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("lsu_pipe: unsupported parameter value");
        end
    endgenerate

    assign eff_addr = base_addr + XLEN'($signed(imm));
    assign lane     = eff_addr[LW-1:0];

    // Which func3 codes exist for the requested direction at this XLEN
    always_comb begin
        code_ok = 1'b0;
        if (req_load) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: code_ok = 1'b1;
                3'b011, 3'b110:                         code_ok = (XLEN == 64);
                default:                                code_ok = 1'b0;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b001, 3'b010: code_ok = 1'b1;
                3'b011:                 code_ok = (XLEN == 64);
                default:                code_ok = 1'b0;
            endcase
        end
    end

    assign illegal = (req_load == req_store) || !code_ok;

    // Access size comes from func3[1:0]; derive alignment check and base strobe from it
    always_comb begin
        case (func3[1:0])
            2'd0: begin misaligned = 1'b0;            strb_base = NB'(8'h01); end
            2'd1: begin misaligned = eff_addr[0];     strb_base = NB'(8'h03); end
            2'd2: begin misaligned = |eff_addr[1:0];  strb_base = NB'(8'h0F); end
            default: begin misaligned = |eff_addr[2:0]; strb_base = NB'(8'hFF); end
        endcase
    end

    assign rsp_shifted = mem_rdata >> {addr_q[LW-1:0], 3'b000};

    // Extract the addressed bytes from the returned word and extend to XLEN
    always_comb begin
        case (func3_q)
            3'b000:  load_ext = XLEN'($signed(rsp_shifted[7:0]));
            3'b001:  load_ext = XLEN'($signed(rsp_shifted[15:0]));
            3'b010:  load_ext = XLEN'($signed(rsp_shifted[31:0]));
            3'b100:  load_ext = XLEN'(rsp_shifted[7:0]);
            3'b101:  load_ext = XLEN'(rsp_shifted[15:0]);
            3'b110:  load_ext = XLEN'(rsp_shifted[31:0]);
            default: load_ext = rsp_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Access sequencer: all outputs are registered and pulses last exactly one cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            req_ready     <= 1'b1;
            busy          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= '0;
            mem_wdata     <= '0;
            done          <= 1'b0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            fault_valid   <= 1'b0;
            fault_cause   <= '0;
            fault_addr    <= '0;
            addr_q        <= '0;
            func3_q       <= '0;
            rd_q          <= '0;
            load_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        addr_q    <= eff_addr;
                        func3_q   <= func3;
                        rd_q      <= req_rd;
                        load_q    <= req_load;
                        if (illegal || misaligned) begin
                            state       <= S_FAULT;
                            fault_valid <= 1'b1;
                            done        <= 1'b1;
                            fault_cause <= illegal ? 2'd1 : 2'd0;
                            fault_addr  <= eff_addr;
                        end else begin
                            state         <= S_REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= {eff_addr[XLEN-1:LW], LW'(0)};
                            mem_we        <= req_store;
                            mem_wstrb     <= req_store ? (strb_base << lane) : '0;
                            mem_wdata     <= req_store ? (store_data << {lane, 3'b000}) : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        state <= S_RESP;
                        done  <= 1'b1;
                        if (load_q) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        state       <= S_FAULT;
                        fault_valid <= 1'b1;
                        done        <= 1'b1;
                        fault_cause <= 2'd2;
                        fault_addr  <= addr_q;
                    end else begin
`ifdef LSU_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP, S_FAULT: begin
                    state       <= S_IDLE;
                    done        <= 1'b0;
                    wb_valid    <= 1'b0;
                    fault_valid <= 1'b0;
                    req_ready   <= 1'b1;
                    busy        <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
